// File: rtl/matrix_scan_if.sv
// Frame-RAM read port and HUB75 panel signals of the matrix scanner.
// The master side is the scanner; the slave side is the RAM plus panel.
interface matrix_scan_if;
  logic [11:0] ram_address;
  logic [7:0]  ram_data_in;
  logic [2:0]  rgb_top;
  logic [2:0]  rgb_bottom;
  logic [3:0]  row_addr;
  logic        panel_clk;
  logic        latch;
  logic        oe_n;
  logic        frame_sync;

  modport master (
    output ram_address, rgb_top, rgb_bottom, row_addr, panel_clk, latch, oe_n, frame_sync,
    input  ram_data_in
  );

  modport slave (
    input  ram_address, rgb_top, rgb_bottom, row_addr, panel_clk, latch, oe_n, frame_sync,
    output ram_data_in
  );
endinterface

// File: rtl/matrix_scan.sv
// HUB75 scanner: reads RGB565 pixels from the frame RAM and drives a 64x32,
// 1/16-scan panel with binary-coded modulation over six bit planes.
// All panel outputs are registered and decoded from the next scan position,
// so each output reflects the position held in the counters during a cycle.
module matrix_scan #(
  parameter int unsigned DISPLAY_BASE  = 8,
  parameter int unsigned DISPLAY_WIDTH = 12
) (
  input  logic          clk_in,
  input  logic          reset_n,
  input  logic [2:0]    rgb_enable,
  input  logic [5:0]    brightness_enable,
  matrix_scan_if.master bus
);

  typedef enum logic [1:0] {ST_SHIFT, ST_BLANK, ST_LATCH, ST_DISPLAY} state_t;

  localparam logic [DISPLAY_WIDTH-1:0] BASE_W = DISPLAY_WIDTH'(DISPLAY_BASE);
  localparam logic [DISPLAY_WIDTH-1:0] ONE_W  = DISPLAY_WIDTH'(1);

  state_t                   state, state_nxt;
  logic                     running;
  logic [3:0]               row, row_nxt;
  logic [2:0]               plane, plane_nxt;
  logic [5:0]               col, col_nxt;
  logic [2:0]               phase, phase_nxt;
  logic [DISPLAY_WIDTH-1:0] disp_cnt, disp_cnt_nxt;

  logic [2:0]  rgb_en_meta, rgb_en_sync;
  logic [5:0]  bright_meta, bright_sync;
  logic [7:0]  top_hi, top_lo, bot_hi;
  logic [11:0] addr_nxt;

  // RGB565 -> one bit of each 6-bit channel for plane b, masked by channel enables.
  function automatic logic [2:0] pixel_bits(input logic [7:0] hi, input logic [7:0] lo,
                                            input logic [2:0] b, input logic [2:0] en);
    logic [5:0] r6, g6, b6;
    r6 = {hi[7:3], hi[7]};
    g6 = {hi[2:0], lo[7:5]};
    b6 = {lo[4:0], lo[4]};
    return {b6[b] & en[2], g6[b] & en[1], r6[b] & en[0]};
  endfunction

  // Two-flop synchronisers for the quasi-static enables from the decoder domain.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      rgb_en_meta <= '0;
      rgb_en_sync <= '0;
      bright_meta <= '0;
      bright_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values, forming a true 2-stage chain.
      rgb_en_meta <= rgb_enable;
      rgb_en_sync <= rgb_en_meta;
      bright_meta <= brightness_enable;
      bright_sync <= bright_meta;
    end
  end

  // Next scan position: column phases, planes, rows and the BCM display timer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_nxt    = state;
    row_nxt      = row;
    plane_nxt    = plane;
    col_nxt      = col;
    phase_nxt    = phase;
    disp_cnt_nxt = disp_cnt;
    if (running) begin
      unique case (state)
        ST_SHIFT: begin
          if (phase == 3'd6) begin
            phase_nxt = 3'd0;
            if (col == 6'd63) begin
              col_nxt   = 6'd0;
              state_nxt = ST_BLANK;
            end else begin
              col_nxt = col + 6'd1;
            end
          end else begin
            phase_nxt = phase + 3'd1;
          end
        end
        ST_BLANK: state_nxt = ST_LATCH;
        ST_LATCH: begin
          state_nxt    = ST_DISPLAY;
          disp_cnt_nxt = (BASE_W << plane) - ONE_W;
        end
        ST_DISPLAY: begin
          if (disp_cnt == '0) begin
            state_nxt = ST_SHIFT;
            if (plane != 3'd0) begin
              plane_nxt = plane - 3'd1;
            end else begin
              plane_nxt = 3'd5;
              row_nxt   = row + 4'd1;
            end
          end else begin
            disp_cnt_nxt = disp_cnt - ONE_W;
          end
        end
        default: state_nxt = ST_SHIFT;
      endcase
    end
  end

  // Read address for the next cycle: phases 0..3 fetch top-hi, top-lo, bottom-hi, bottom-lo.
  always_comb begin
    addr_nxt = bus.ram_address;
    if (state_nxt == ST_SHIFT && !phase_nxt[2]) begin
      addr_nxt = {phase_nxt[1], row_nxt, col_nxt, ~phase_nxt[0]};
    end
  end

  // Scan position register; the first edge after reset only starts the scan at p0.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_SHIFT;
      running  <= 1'b0;
      row      <= 4'd0;
      plane    <= 3'd5;
      col      <= 6'd0;
      phase    <= 3'd0;
      disp_cnt <= '0;
    end else begin
      running  <= 1'b1;
      state    <= state_nxt;
      row      <= row_nxt;
      plane    <= plane_nxt;
      col      <= col_nxt;
      phase    <= phase_nxt;
      disp_cnt <= disp_cnt_nxt;
    end
  end

  // Byte capture for the pixel pair being shifted.
  // NOTE: pure datapath registers are always written before being read, so they carry no reset.
  always_ff @(posedge clk_in) begin
    if (state == ST_SHIFT) begin
      case (phase)
        3'd1:    top_hi <= bus.ram_data_in;
        3'd2:    top_lo <= bus.ram_data_in;
        3'd3:    bot_hi <= bus.ram_data_in;
        default: ;
      endcase
    end
  end

  // Registered panel and RAM outputs; reset forces them asynchronously (oe_n high at once).
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      bus.ram_address <= 12'd0;
      bus.rgb_top     <= 3'd0;
      bus.rgb_bottom  <= 3'd0;
      bus.row_addr    <= 4'd0;
      bus.panel_clk   <= 1'b0;
      bus.latch       <= 1'b0;
      bus.oe_n        <= 1'b1;
      bus.frame_sync  <= 1'b0;
    end else begin
      bus.ram_address <= addr_nxt;
      bus.panel_clk   <= (state_nxt == ST_SHIFT) && (phase_nxt == 3'd6);
      bus.latch       <= (state_nxt == ST_LATCH);
      bus.frame_sync  <= (state_nxt == ST_SHIFT) && (row_nxt == 4'd0) && (plane_nxt == 3'd5) &&
                         (col_nxt == 6'd0) && (phase_nxt == 3'd0);
      if (state == ST_SHIFT && phase == 3'd4) begin
        bus.rgb_top    <= pixel_bits(top_hi, top_lo, plane, rgb_en_sync);
        bus.rgb_bottom <= pixel_bits(bot_hi, bus.ram_data_in, plane, rgb_en_sync);
      end
      if (state == ST_BLANK) begin
        bus.row_addr <= row;
      end
      // Plane enable is sampled once on DISPLAY entry and held for the whole period.
      if (state_nxt == ST_DISPLAY) begin
        if (state != ST_DISPLAY) begin
          bus.oe_n <= ~bright_sync[plane];
        end
      end else begin
        bus.oe_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan.sv
// Self-checking bench for matrix_scan: random frame RAM, a reference model
// of the scan order and pixel decode feeding expectation queues, and a
// monitor that checks every panel_clk pixel and every latched plane.
module tb_matrix_scan;

  typedef struct { int r; int b; int col; logic [5:0] bits; } pix_exp_t;
  typedef struct { int r; int b; int oe_low; } plane_exp_t;

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic [2:0] rgb_enable;
  logic [5:0] brightness_enable;
  logic [7:0] mem [4096];

  int checks = 0;
  int errors = 0;

  pix_exp_t   pix_q[$];
  plane_exp_t plane_q[$];

  matrix_scan_if bus();

  matrix_scan #(.DISPLAY_BASE(8), .DISPLAY_WIDTH(12)) dut (
    .clk_in            (clk_in),
    .reset_n           (reset_n),
    .rgb_enable        (rgb_enable),
    .brightness_enable (brightness_enable),
    .bus               (bus)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous-read frame RAM: data follows the address by one cycle.
  always @(posedge clk_in) bus.ram_data_in <= mem[bus.ram_address];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // {B,G,R} bits of one panel pixel for plane b, computed from the RGB565 word.
  function automatic logic [2:0] expect_bits(int half, int r, int col, int b, logic [2:0] en);
    int base, pixel, red6, green6, blue6;
    base   = half * 2048 + r * 128 + col * 2;
    pixel  = int'(mem[base + 1]) * 256 + int'(mem[base]);
    red6   = (pixel / 2048) * 2 + (pixel / 2048) / 16;
    green6 = (pixel / 32) % 64;
    blue6  = (pixel % 32) * 2 + (pixel % 32) / 16;
    return {en[2] && ((blue6 >> b) & 1) == 1,
            en[1] && ((green6 >> b) & 1) == 1,
            en[0] && ((red6 >> b) & 1) == 1};
  endfunction

  // Expected panel activity for a number of row pairs starting at row 0, plane 5.
  task automatic push_run(input int pairs, input logic [2:0] en, input logic [5:0] br);
    pix_q.delete();
    plane_q.delete();
    for (int k = 0; k < pairs; k++) begin
      for (int b = 5; b >= 0; b--) begin
        plane_exp_t pe;
        pe.r = k % 16;
        pe.b = b;
        pe.oe_low = br[b] ? (8 << b) : 0;
        plane_q.push_back(pe);
        for (int c = 0; c < 64; c++) begin
          pix_exp_t px;
          px.r = k % 16;
          px.b = b;
          px.col = c;
          px.bits = {expect_bits(1, k % 16, c, b, en), expect_bits(0, k % 16, c, b, en)};
          pix_q.push_back(px);
        end
      end
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h001] = 8'hF8;  // top row 0, col 0: pure red
    mem[12'h000] = 8'h00;
    mem[12'h002] = 8'h00;  // col 1 black
    mem[12'h003] = 8'h00;
    mem[12'h800] = 8'h1F;  // bottom row 0, col 0: pure blue
    mem[12'h801] = 8'h00;
  endtask

  // Monitor state.
  logic       prev_pclk;
  int         pclk_count, since_pclk, oe_count;
  bit         have_plane;
  plane_exp_t cur_plane;

  // Monitor: pixels at each panel_clk rise, plane bookkeeping at each latch.
  always @(negedge clk_in) begin
    if (!reset_n) begin
      prev_pclk  = 1'b0;
      pclk_count = 0;
      since_pclk = 0;
      oe_count   = 0;
      have_plane = 1'b0;
    end else begin
      since_pclk++;
      if (!bus.oe_n) oe_count++;
      if (bus.panel_clk && !prev_pclk) begin
        since_pclk = 0;
        pclk_count++;
        if (pix_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pixel_queue: unexpected panel_clk, no pixel expected (t=%0t)", $time);
        end else begin
          pix_exp_t px;
          px = pix_q.pop_front();
          check($sformatf("pixel r%0d b%0d col%0d {bot,top}", px.r, px.b, px.col),
                {26'd0, bus.rgb_bottom, bus.rgb_top}, {26'd0, px.bits});
        end
      end
      prev_pclk = bus.panel_clk;
      if (bus.latch) begin
        check("latch_2_cycles_after_last_panel_clk", since_pclk, 2);
        check("panel_clks_per_plane", pclk_count, 64);
        pclk_count = 0;
        if (have_plane)
          check($sformatf("oe_low_cycles r%0d b%0d", cur_plane.r, cur_plane.b), oe_count, cur_plane.oe_low);
        oe_count = 0;
        if (plane_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL plane_queue: unexpected latch, no plane expected (t=%0t)", $time);
          have_plane = 1'b0;
        end else begin
          cur_plane = plane_q.pop_front();
          have_plane = 1'b1;
          check($sformatf("row_addr at latch b%0d", cur_plane.b), bus.row_addr, cur_plane.r);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_address"}, bus.ram_address, 0);
    check({tag, "_rgb_top"}, bus.rgb_top, 0);
    check({tag, "_rgb_bottom"}, bus.rgb_bottom, 0);
    check({tag, "_row_addr"}, bus.row_addr, 0);
    check({tag, "_panel_clk"}, bus.panel_clk, 0);
    check({tag, "_latch"}, bus.latch, 0);
    check({tag, "_oe_n"}, bus.oe_n, 1);
    check({tag, "_frame_sync"}, bus.frame_sync, 0);
  endtask

  task automatic check_startup(input string tag);
    @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);
    check({tag, "_frame_sync_first_cycle"}, bus.frame_sync, 1);
    check({tag, "_ram_address_p0"}, bus.ram_address, 12'h001);
    @(negedge clk_in);
    check({tag, "_frame_sync_one_cycle"}, bus.frame_sync, 0);
    check({tag, "_ram_address_p1"}, bus.ram_address, 12'h000);
  endtask

  initial begin
    int  cyc;
    bit  found;
    logic [5:0] br;

    // Run 1: full frame, red/blue directed pixels, only plane 0 lit.
    reset_n = 1'b0;
    rgb_enable = 3'b111;
    brightness_enable = 6'b000001;
    fill_mem();
    repeat (3) @(negedge clk_in);
    check_reset_outputs("reset_held");
    push_run(17, 3'b111, 6'b000001);
    check_startup("run1");

    cyc = 1;
    found = 1'b0;
    while (cyc < 60000 && !found) begin
      @(negedge clk_in);
      cyc++;
      if (bus.frame_sync) found = 1'b1;
    end
    check("frame_period_cycles", cyc, 51264);
    check("row_addr_at_frame_wrap", bus.row_addr, 15);
    repeat (500) @(negedge clk_in);
    check("row_addr_after_wrap", bus.row_addr, 0);

    // Run 2: red masked off, random plane enables, reset mid-DISPLAY.
    reset_n = 1'b0;
    rgb_enable = 3'b110;
    br = 6'($urandom) | 6'b000001;
    brightness_enable = br;
    fill_mem();
    repeat (2) @(negedge clk_in);
    push_run(2, 3'b110, br);
    check_startup("run2");
    repeat (3300) @(negedge clk_in);
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk_in);
      if (!bus.oe_n) found = 1'b1;
    end
    check("oe_n_low_seen_before_reset", found, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_oe_n", bus.oe_n, 1);
    check("async_reset_latch", bus.latch, 0);
    check("async_reset_panel_clk", bus.panel_clk, 0);

    // Run 3: restart after the mid-DISPLAY reset, all planes lit.
    rgb_enable = 3'b111;
    brightness_enable = 6'b111111;
    fill_mem();
    repeat (2) @(negedge clk_in);
    push_run(1, 3'b111, 6'b111111);
    check_startup("run3");
    repeat (1300) @(negedge clk_in);
    check("run3_row_addr", bus.row_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_scan.md
# matrix_scan

Display-side consumer of the 4 KiB frame RAM that the UART command decoder fills. It walks the RAM row pair by row pair and bit plane by bit plane, and converts 16-bit RGB565 pixels into HUB75 shift, latch and output-enable signals with binary-coded modulation (BCM). It applies the decoder's `rgb_enable` and `brightness_enable` masks. It owns the RAM read port and drives a 64x32, 1/16-scan panel.

## Interface
- `DISPLAY_BASE`, default 8: display cycles for bit plane 0; plane b displays for `DISPLAY_BASE << b` cycles.
- `DISPLAY_WIDTH`, default 12: display counter width. `DISPLAY_BASE*32` must be less than `2**DISPLAY_WIDTH`.
- `clk_in`  in  1  single clock for the whole block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rgb_enable`  in  3  [0]=R, [1]=G, [2]=B channel enables; driven from the decoder's domain.
- `brightness_enable`  in  6  per-bit-plane enables, [5]=MSB; driven from the decoder's domain.
- `ram_address`  out  12  read address `{row[4:0], col[5:0], sel}`; sel=1 selects the high byte.
- `ram_data_in`  in  8  RAM read data, valid exactly 1 cycle after `ram_address`.
- `rgb_top`  out  3  {B,G,R} bits for panel row r.
- `rgb_bottom`  out  3  {B,G,R} bits for panel row r+16.
- `row_addr`  out  4  HUB75 A–D row select.
- `panel_clk`  out  1  shift clock; panel samples on the rising edge.
- `latch`  out  1  shift-register latch strobe.
- `oe_n`  out  1  output enable, active low.
- `frame_sync`  out  1  one-cycle pulse at the start of each frame.

## Operation
- Input synchronisation:
  - Both enable vectors are quasi-static and pass through a 2-flop synchroniser.
  - The synchronised `rgb_enable` is used at column phase 4.
  - The synchronised `brightness_enable[b]` is sampled on entry to DISPLAY.
- Counters: row r (4 bits, 0..15), plane b (5 down to 0), col (6 bits), column phase p (0..6), display counter.
- Pixel decode: pixel = {hi, lo}.
  - R5 = hi[7:3].
  - G6 = {hi[2:0], lo[7:5]}.
  - B5 = lo[4:0].
  - R6 = {R5, R5[4]}; B6 = {B5, B5[4]}.
  - Output bit for each channel = channel6[b] & rgb_enable[channel].
- SHIFT state, per column, 7 phases:
  - p0: address top-hi `{0,r,col,1}`.
  - p1: capture data; address top-lo `{0,r,col,0}`.
  - p2: capture data; address bottom-hi `{1,r,col,1}`.
  - p3: capture data; address bottom-lo `{1,r,col,0}`.
  - p4: `ram_data_in` is the bottom-lo byte; `rgb_top` and `rgb_bottom` are registered at the end of p4.
  - p5: rgb outputs stable, `panel_clk`=0.
  - p6: `panel_clk`=1.
  - After p6 of col 63, go to BLANK; otherwise col+1, p0.
- BLANK (1 cycle): `oe_n`=1. `row_addr` loads r at the end of this cycle.
- LATCH (1 cycle): `latch`=1, `oe_n`=1.
- DISPLAY:
  - Lasts `DISPLAY_BASE << b` cycles.
  - `oe_n` = ~brightness_enable[b] for the whole period.
  - When it ends, `oe_n` returns to 1. Then:
    - if b>0: b-1, re-enter SHIFT at col 0.
    - else: b=5, r=(r+1) mod 16, SHIFT.
- `frame_sync` = 1 during the first SHIFT cycle with r=0, b=5, col=0, p=0.
- `panel_clk` is 0 in every state except SHIFT p6.
- `latch` is 0 outside LATCH.
- `oe_n` is 1 outside DISPLAY.

## Timing
- Reset values: `ram_address`=0, `rgb_top`=0, `rgb_bottom`=0, `row_addr`=0, `panel_clk`=0, `latch`=0, `oe_n`=1, `frame_sync`=0, state=SHIFT, r=0, b=5, col=0, p=0.
- Assertion of `reset_n` forces the reset values immediately, including mid-DISPLAY: `oe_n` goes high with no clock.
- First clock edge after `reset_n` deasserts: the block is in SHIFT r=0, b=5, col=0, p=0, and `frame_sync`=1 in that cycle.
- Plane period = 448 (SHIFT) + 1 (BLANK) + 1 (LATCH) + `DISPLAY_BASE << b` cycles.
- Row pair = 6·450 + 63·`DISPLAY_BASE` cycles: 3204 at the default.
- Frame = 16 row pairs: 51264 cycles at the default.
- Relative to `panel_clk` rising: rgb setup is 1 cycle (p5), hold is until the p4 of the next column.
- Changes to `rgb_enable` appear in output data within 3 cycles plus the next p4. Changes to `brightness_enable` take effect at the next DISPLAY entry.
- The RAM may be written concurrently by the decoder. A torn pixel is acceptable; no interlock.

## Test plan
- Reset and startup:
  - Hold `reset_n`=0 → all outputs at reset values, `oe_n`=1.
  - Release → `frame_sync`=1 on the first cycle, `ram_address`=0x001 at p0.
  - Next `frame_sync` is exactly 51264 cycles later (default parameters).
- Pure red pixel: preload 0x001=0xF8, 0x000=0x00, all other addresses 0, enables all 1.
  - Plane 5, col 0: at p5 `rgb_top`=3'b001, `rgb_bottom`=3'b000.
  - Col 1: `rgb_top`=000.
- Channel mask: same RAM, `rgb_enable`=3'b110 → `rgb_top` stays 000 for all planes.
- Bottom half, blue: preload 0x800=0x1F, 0x801=0x00 → `rgb_bottom`=3'b100 at col 0 for planes 5..0.
- BCM gating: `brightness_enable`=6'b000001.
  - `oe_n` stays 1 through the 256-cycle plane-5 DISPLAY.
  - `oe_n` is 0 for exactly 8 cycles in the plane-0 DISPLAY.
  - `latch` pulses once per plane, 1 cycle after BLANK.
- Row wrap and reset mid-operation:
  - After r=15, plane 0 → `row_addr` goes 0 and `frame_sync` pulses.
  - Asserting `reset_n` mid-DISPLAY with `oe_n`=0 → `oe_n`=1 asynchronously, and the block restarts at r=0, b=5.
